// File: rtl/slow_op_initiator.sv
// Requester side of the req/ack handshake to a non-pipelined slow functional unit.
// Holds one operation at a time, returns its result to writeback, and flags timeouts and stray acks.
module slow_op_initiator #(
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [31:0]      issue_p0,
  input  logic [31:0]      issue_p1,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             issue_ready,
  output logic             stall,
  output logic             req,
  output logic [31:0]      p0,
  output logic [31:0]      p1,
  input  logic             ack,
  input  logic [31:0]      res,
  output logic             wb_valid,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             wb_err,
  input  logic             wb_ready,
  output logic             spurious_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_t;

  // Counter value seen in the last permitted REQ cycle; timing out there gives TIMEOUT cycles of req.
  localparam int unsigned      TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_LAST_I);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag;

  assign issue_ready = (state == IDLE);
  assign stall       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      tag          <= '0;
      req          <= 1'b0;
      p0           <= '0;
      p1           <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_tag       <= '0;
      wb_err       <= 1'b0;
      spurious_ack <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ack) spurious_ack <= 1'b1;
          if (issue_valid) begin
            p0    <= issue_p0;
            p1    <= issue_p1;
            tag   <= issue_tag;
            req   <= 1'b1;
            cnt   <= '0;
            state <= REQ;
          end
        end
        REQ: begin
          // ack takes priority over a coincident timeout
          if (ack) begin
            wb_data  <= res;
            wb_tag   <= tag;
            wb_err   <= 1'b0;
            wb_valid <= 1'b1;
            req      <= 1'b0;
            state    <= WB;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            wb_data  <= '0;
            wb_tag   <= tag;
            wb_err   <= 1'b1;
            wb_valid <= 1'b1;
            req      <= 1'b0;
            state    <= WB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB: begin
          if (ack) spurious_ack <= 1'b1;
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          req      <= 1'b0;
          wb_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slow_op_initiator.sv
// Bench for slow_op_initiator: directed vector table, hand-written corner sequences,
// and random traffic, all compared against a transaction-level reference model.
module tb_slow_op_initiator;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [31:0] issue_p0, issue_p1;
  logic [4:0]  issue_tag;
  logic        issue_ready, stall, req;
  logic [31:0] p0, p1;
  logic        ack;
  logic [31:0] res;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_tag;
  logic        wb_err, wb_ready, spurious_ack;

  slow_op_initiator #(.TAG_W(5), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_p0(issue_p0), .issue_p1(issue_p1), .issue_tag(issue_tag),
    .issue_ready(issue_ready), .stall(stall),
    .req(req), .p0(p0), .p1(p1), .ack(ack), .res(res),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_tag(wb_tag), .wb_err(wb_err),
    .wb_ready(wb_ready), .spurious_ack(spurious_ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: an operation is "in flight" from its accept edge, and its fate is decided
  // by elapsed edges since acceptance; a finished result sits in a one-entry writeback slot.
  bit          m_inflight, m_slot, m_spur;
  int unsigned cyc, m_start;
  logic [31:0] m_p0, m_p1, m_data;
  logic [4:0]  m_tag, m_wtag;
  bit          m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_inflight = 0; m_slot = 0; m_spur = 0;
    m_data = '0; m_wtag = '0; m_err = 0;
  endtask

  task automatic compare_all();
    chk("issue_ready", 32'(issue_ready), 32'(!m_inflight && !m_slot));
    chk("stall", 32'(stall), 32'(m_inflight || m_slot));
    chk("req", 32'(req), 32'(m_inflight));
    chk("wb_valid", 32'(wb_valid), 32'(m_slot));
    chk("spurious_ack", 32'(spurious_ack), 32'(m_spur));
    if (m_inflight) begin
      chk("p0", p0, m_p0);
      chk("p1", p1, m_p1);
    end
    if (m_slot) begin
      chk("wb_data", wb_data, m_data);
      chk("wb_tag", 32'(wb_tag), 32'(m_wtag));
      chk("wb_err", 32'(wb_err), 32'(m_err));
    end
  endtask

  // One clock: model consumes the inputs present at the edge, then DUT is compared 1ns later.
  task automatic step();
    cyc++;
    if (m_inflight) begin
      if (ack) begin
        m_inflight = 0; m_slot = 1; m_data = res; m_wtag = m_tag; m_err = 0;
      end else if (TO != 0 && cyc - m_start == TO) begin
        m_inflight = 0; m_slot = 1; m_data = '0; m_wtag = m_tag; m_err = 1;
      end
    end else begin
      if (ack) m_spur = 1;
      if (m_slot) begin
        if (wb_ready) m_slot = 0;
      end else if (issue_valid) begin
        m_inflight = 1; m_start = cyc;
        m_p0 = issue_p0; m_p1 = issue_p1; m_tag = issue_tag;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit iv, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input bit ak, input logic [31:0] r, input bit wr);
    issue_valid = iv; issue_p0 = a; issue_p1 = b; issue_tag = t;
    ack = ak; res = r; wb_ready = wr;
  endtask

  typedef struct {
    bit          iv;
    logic [31:0] ip0, ip1;
    logic [4:0]  itag;
    bit          ak;
    logic [31:0] r;
    bit          wr;
    bit          e_req, e_wbv, e_ready;
    logic [31:0] e_data;
    logic [4:0]  e_tag;
  } vec_t;

  vec_t tbl[8];
  logic [31:0] held;

  initial begin
    // Basic op: accept, five cycles of req, ack with 42, one cycle of backpressure, retire.
    tbl[0] = '{1, 32'd7, 32'd6, 5'd3, 0, 32'd0,  0, 1, 0, 0, 32'd0,  5'd0};
    tbl[1] = '{0, 32'd0, 32'd0, 5'd0, 0, 32'd0,  0, 1, 0, 0, 32'd0,  5'd0};
    tbl[2] = '{0, 32'd0, 32'd0, 5'd0, 0, 32'd0,  0, 1, 0, 0, 32'd0,  5'd0};
    tbl[3] = '{0, 32'd0, 32'd0, 5'd0, 0, 32'd0,  0, 1, 0, 0, 32'd0,  5'd0};
    tbl[4] = '{0, 32'd0, 32'd0, 5'd0, 0, 32'd0,  0, 1, 0, 0, 32'd0,  5'd0};
    tbl[5] = '{0, 32'd0, 32'd0, 5'd0, 1, 32'd42, 0, 0, 1, 0, 32'd42, 5'd3};
    tbl[6] = '{0, 32'd0, 32'd0, 5'd0, 0, 32'd0,  0, 0, 1, 0, 32'd42, 5'd3};
    tbl[7] = '{0, 32'd0, 32'd0, 5'd0, 0, 32'd0,  1, 0, 0, 1, 32'd0,  5'd0};

    cyc = 0; m_start = 0; model_clear();
    rst = 1'b1;
    drive(0, '0, '0, '0, 0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset wb_tag", 32'(wb_tag), 32'd0);
    chk("reset p0", p0, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready after reset", 32'(issue_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].iv, tbl[i].ip0, tbl[i].ip1, tbl[i].itag, tbl[i].ak, tbl[i].r, tbl[i].wr);
      step();
      chk($sformatf("vec%0d req", i), 32'(req), 32'(tbl[i].e_req));
      chk($sformatf("vec%0d wb_valid", i), 32'(wb_valid), 32'(tbl[i].e_wbv));
      chk($sformatf("vec%0d issue_ready", i), 32'(issue_ready), 32'(tbl[i].e_ready));
      if (tbl[i].e_wbv) begin
        chk($sformatf("vec%0d wb_data", i), wb_data, tbl[i].e_data);
        chk($sformatf("vec%0d wb_tag", i), 32'(wb_tag), 32'(tbl[i].e_tag));
        chk($sformatf("vec%0d wb_err", i), 32'(wb_err), 32'd0);
      end
    end

    // Zero-wait ack with all-ones result.
    drive(1, 32'hA5A5_0001, 32'h5A5A_0002, 5'd11, 0, '0, 0);
    step();
    drive(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd0, 1, 32'hFFFF_FFFF, 0);
    chk("zw p0 stable", p0, 32'hA5A5_0001);
    step();
    chk("zw wb_valid", 32'(wb_valid), 32'd1);
    chk("zw wb_data", wb_data, 32'hFFFF_FFFF);
    chk("zw wb_tag", 32'(wb_tag), 32'd11);

    // Backpressure for 10 cycles, then retire with issue_valid held: req must be low one cycle.
    drive(0, '0, '0, '0, 0, '0, 0);
    held = wb_data;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp wb_data", wb_data, held);
      chk("bp stall", 32'(stall), 32'd1);
      chk("bp req", 32'(req), 32'd0);
    end
    drive(1, 32'd100, 32'd200, 5'd20, 0, '0, 1);
    step();
    chk("retire wb_valid", 32'(wb_valid), 32'd0);
    chk("retire req low", 32'(req), 32'd0);
    chk("retire ready", 32'(issue_ready), 32'd1);
    drive(1, 32'd100, 32'd200, 5'd20, 0, '0, 0);
    step();
    chk("b2b req", 32'(req), 32'd1);
    drive(0, '0, '0, '0, 1, 32'd300, 0);
    step();
    drive(0, '0, '0, '0, 0, '0, 1);
    step();

    // Timeout with no ack: req holds for TO cycles, then error result.
    drive(1, 32'd9, 32'd10, 5'd17, 0, '0, 0);
    step();
    drive(0, '0, '0, '0, 0, '0, 0);
    for (int i = 0; i < TO - 1; i++) begin
      step();
      chk("to req held", 32'(req), 32'd1);
    end
    step();
    chk("to req drop", 32'(req), 32'd0);
    chk("to wb_err", 32'(wb_err), 32'd1);
    chk("to wb_data", wb_data, 32'd0);
    chk("to wb_tag", 32'(wb_tag), 32'd17);
    drive(0, '0, '0, '0, 0, '0, 1);
    step();

    // Ack in the last permitted cycle wins over the timeout.
    drive(1, 32'd1, 32'd2, 5'd18, 0, '0, 0);
    step();
    drive(0, '0, '0, '0, 0, '0, 0);
    repeat (TO - 1) step();
    drive(0, '0, '0, '0, 1, 32'h1234, 0);
    step();
    chk("to-ack wb_err", 32'(wb_err), 32'd0);
    chk("to-ack wb_data", wb_data, 32'h1234);
    drive(0, '0, '0, '0, 0, '0, 1);
    step();

    // Spurious acks in IDLE and in WB.
    drive(0, '0, '0, '0, 1, 32'h7777, 0);
    step();
    chk("spur idle", 32'(spurious_ack), 32'd1);
    drive(1, 32'd3, 32'd4, 5'd5, 0, '0, 0);
    step();
    drive(0, '0, '0, '0, 1, 32'd12, 0);
    step();
    drive(0, '0, '0, '0, 1, 32'h9999, 0);
    step();
    chk("spur wb data kept", wb_data, 32'd12);
    drive(0, '0, '0, '0, 0, '0, 1);
    step();
    drive(1, 32'd8, 32'd8, 5'd6, 0, '0, 0);
    step();
    drive(0, '0, '0, '0, 1, 32'd64, 0);
    step();
    chk("post-spur data", wb_data, 32'd64);
    chk("post-spur sticky", 32'(spurious_ack), 32'd1);
    drive(0, '0, '0, '0, 0, '0, 1);
    step();

    // Async reset in the middle of REQ.
    drive(1, 32'd50, 32'd51, 5'd9, 0, '0, 0);
    step();
    drive(0, '0, '0, '0, 0, '0, 0);
    step();
    #3;
    rst = 1'b1;
    model_clear();
    #1;
    compare_all();
    chk("arst req", 32'(req), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, '0, '0, '0, 1, 32'hBAD0_BAD0, 0);
    step();
    drive(1, 32'd70, 32'd71, 5'd4, 0, '0, 0);
    step();
    drive(0, '0, '0, '0, 1, 32'd77, 0);
    step();
    chk("arst new data", wb_data, 32'd77);
    chk("arst new tag", 32'(wb_tag), 32'd4);
    drive(0, '0, '0, '0, 0, '0, 1);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom, $urandom, 5'($urandom),
            $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 2) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slow_op_initiator.md
Name: slow_op_initiator

Overview:
- Requester (initiator) end of the req/ack slow-functional-unit handshake, e.g. the non-pipelined 32x32 multiplier.
- Accepts one operation from the CPU issue stage and drives req/p0/p1 to the slow unit, holding them stable until ack.
- Captures the result and presents it to writeback with its destination tag; stalls issue while an operation is outstanding.
- Detects missing acks (timeout) and acks that arrive while no request is outstanding (spurious).

Parameters:
- TAG_W, 5: width of the destination register tag.
- TIMEOUT, 1024: cycles in REQ without ack before abort; 0 disables the timeout.
- CNT_W, 16: width of the wait counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  operation offered by the issue stage.
- issue_p0  in  32  operand 0.
- issue_p1  in  32  operand 1.
- issue_tag  in  TAG_W  destination tag.
- issue_ready  out  1  initiator can accept an operation.
- stall  out  1  operation outstanding or result unretired.
- req  out  1  request to the slow unit.
- p0  out  32  operand 0 to the slow unit.
- p1  out  32  operand 1 to the slow unit.
- ack  in  1  single-cycle completion pulse from the slow unit.
- res  in  32  slow-unit result; valid only in the ack cycle.
- wb_valid  out  1  result available for writeback.
- wb_data  out  32  result data.
- wb_tag  out  TAG_W  tag of the result.
- wb_err  out  1  result is a timeout abort; wb_data is 0.
- wb_ready  in  1  writeback accepts the result.
- spurious_ack  out  1  sticky: ack seen outside REQ.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; req=0; p0=p1=0; wb_valid=0; wb_data=0; wb_tag=0; wb_err=0; spurious_ack=0; wait counter=0.
  - issue_ready=1 and stall=0 as soon as rst deasserts.
  - Reset mid-operation drops req at once and discards any in-flight or unretired result.
- States: IDLE, REQ, WB. All outputs are registered except issue_ready and stall.
- issue_ready = (state==IDLE). stall = (state!=IDLE).
- IDLE:
  - On issue_valid=1, latch issue_p0/issue_p1/issue_tag into p0/p1/tag, set req=1, clear counter, go to REQ.
  - Accept edge N gives req high from N+1.
- REQ:
  - req stays 1; p0/p1 stay constant.
  - Counter increments each cycle that ack=0.
  - ack=1 at edge M: wb_data=res, wb_tag=tag, wb_err=0, wb_valid=1, req=0, all effective from M+1; go to WB.
  - Minimum latency from accept to wb_valid is 2 cycles (ack in the first REQ cycle).
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with ack=0: req=0, wb_valid=1, wb_err=1, wb_data=0, wb_tag=tag; go to WB.
  - If ack arrives in the same cycle the counter hits TIMEOUT, ack wins: normal result, no error.
- WB:
  - wb_valid=1 with data/tag/err held stable until wb_ready=1.
  - On wb_valid && wb_ready at edge K: wb_valid=0 and state=IDLE from K+1.
  - issue_ready is 1 at K+1 at the earliest. No issue/retire overlap: one operation outstanding maximum.
- Return-to-zero: req is always low for at least one cycle between two requests, since the WB state separates them.
- Spurious ack: ack=1 while in IDLE or WB sets spurious_ack=1, which stays set until reset. The ack is otherwise ignored and has no effect on wb_data.
- Backpressure: wb_ready held low keeps the FSM in WB indefinitely; stall stays high and req stays low.
- Signals that do not matter per state:
  - p0/p1 are don't-care outside REQ but are not required to clear.
  - issue_p*/issue_tag are ignored when issue_ready=0.

Test Plan:
- Basic op: issue p0=7, p1=6, tag=3. Responder acks 5 cycles after req with res=42 -> req high exactly 5 cycles; wb_valid one cycle after ack with wb_data=42, wb_tag=3, wb_err=0; wb_ready=1 gives issue_ready again 1 cycle later.
- Zero-wait ack: ack in the first REQ cycle with res=0xFFFFFFFF -> wb_valid 2 cycles after the accept edge; p0/p1 stable throughout REQ.
- Backpressure and back-to-back:
  - Hold wb_ready=0 for 10 cycles -> wb_valid/wb_data stable, stall=1, issue_ready=0, req=0.
  - Then wb_ready=1 while issue_valid is held -> next req rises exactly 2 cycles after retire, with at least 1 cycle of req low.
- Timeout: with TIMEOUT=8, never ack -> req drops after 8 REQ cycles; wb_err=1, wb_data=0, wb_tag correct. Repeat with ack in the 8th cycle -> normal result, wb_err=0.
- Spurious ack: pulse ack while in IDLE and again in WB -> spurious_ack=1 and stays set; wb_data unchanged; the next operation still completes correctly.
- Async reset mid-REQ: assert rst between clock edges -> req=0 and wb_valid=0 immediately; after release, a new operation issues cleanly and the stale result is never presented.
